// File: rtl/drum_hit_capture_pkg.sv
// drum_pkg: shared debounce state type, synchroniser depth and counter helpers
package drum_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

    localparam int SYNC_STAGES = 2;

    // About 10 ms at a 25.175 MHz pixel clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/drum_hit_capture_debounce.sv
// drum_debounce: one pad's 2-FF synchroniser, debounce FSM, hit pulse and level
module drum_debounce import drum_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic pad_raw_i,
    output logic hit_pulse_o,
    output logic hit_level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_t              r_state, w_next;
    logic [CW-1:0]          r_cnt, w_cnt_next;
    logic                   r_pulse, w_fire, w_s;

    assign w_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // Synchroniser; reset loads the inactive pad level so no false press appears
    always_ff @(posedge clk) begin
        if (!rst_n_i) r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], pad_raw_i};
    end

    // State register, qualification counter and registered pulse
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_fire;
        end
    end

    // Next state: a change must persist DEBOUNCE_CYCLES synced samples to be accepted
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_fire     = 1'b0;
        case (r_state)
            IDLE: if (w_s) begin
                w_next     = PRESS_WAIT;
                w_cnt_next = CW'(1);
            end
            PRESS_WAIT: if (!w_s) w_next = IDLE;
                else if (r_cnt == LAST) begin
                    w_next = PRESSED;
                    w_fire = 1'b1;
                end else w_cnt_next = r_cnt + CW'(1);
            PRESSED: if (!w_s) begin
                w_next     = RELEASE_WAIT;
                w_cnt_next = CW'(1);
            end
            RELEASE_WAIT: if (w_s) w_next = PRESSED;
                else if (r_cnt == LAST) w_next = IDLE;
                else w_cnt_next = r_cnt + CW'(1);
            default: w_next = IDLE;
        endcase
    end

    // Outputs: level covers the release qualification window too
    always_comb begin
        hit_pulse_o = r_pulse;
        hit_level_o = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    end

endmodule

// File: rtl/drum_hit_capture.sv
// drum_hit_capture: N-pad drum front end (debounce, flash hold, hit counters); HIT_TIMESTAMP_EN adds per-pad hit timestamps
module drum_hit_capture import drum_pkg::*; #(
    parameter int N_PADS          = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FLASH_FRAMES    = 8,
    parameter int CNT_W           = 8,
    parameter bit ACTIVE_LOW      = 1'b0,
    localparam int LP_W           = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n_i,
    input  logic [N_PADS-1:0]         pad_raw_i,
    input  logic                      frame_tick_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
`ifdef HIT_TIMESTAMP_EN
    input  logic [5:0]                seconds_i,
    output logic [N_PADS*6-1:0]       last_hit_sec_o,
`endif
    output logic [N_PADS-1:0]         hit_pulse_o,
    output logic [N_PADS-1:0]         hit_level_o,
    output logic [N_PADS-1:0]         flash_o,
    output logic [N_PADS*CNT_W-1:0]   hit_count_o,
    output logic                      any_hit_o,
    output logic [LP_W-1:0]           last_pad_o
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(sat_max(CNT_W));

    logic [LP_W-1:0] r_last, w_first;

    for (genvar i = 0; i < N_PADS; i++) begin : g_pad
        logic [FW-1:0]    r_flash;
        logic [CNT_W-1:0] r_count;

        drum_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_db (
            .clk         (clk),
            .rst_n_i     (rst_n_i),
            .pad_raw_i   (pad_raw_i[i]),
            .hit_pulse_o (hit_pulse_o[i]),
            .hit_level_o (hit_level_o[i])
        );

        // Flash hold: a hit (re)loads the frame count, frame ticks run it down
        always_ff @(posedge clk) begin
            if (!rst_n_i)                            r_flash <= '0;
            else if (hit_pulse_o[i])                 r_flash <= FLASH_LOAD;
            else if (frame_tick_i && r_flash != '0)  r_flash <= r_flash - FW'(1);
        end

        // Saturating hit counter; clear wins over a coincident hit
        always_ff @(posedge clk) begin
            if (!rst_n_i || clear_i)                                 r_count <= '0;
            else if (enable_i && hit_pulse_o[i] && r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
        end

`ifdef HIT_TIMESTAMP_EN
        logic [5:0] r_sec;

        // Timestamp of this pad's most recent hit
        always_ff @(posedge clk) begin
            if (!rst_n_i || clear_i) r_sec <= '0;
            else if (hit_pulse_o[i]) r_sec <= seconds_i;
        end

        assign last_hit_sec_o[i*6 +: 6] = r_sec;
`endif

        assign flash_o[i]                   = (r_flash != '0);
        assign hit_count_o[i*CNT_W +: CNT_W] = r_count;
    end

    assign any_hit_o  = |hit_pulse_o;
    assign last_pad_o = r_last;

    // Priority encoder: lowest pulsing pad index wins
    always_comb begin
        w_first = '0;
        for (int k = N_PADS - 1; k >= 0; k--) if (hit_pulse_o[k]) w_first = LP_W'(k);
    end

    // Most recent hit pad, held between hits and untouched by clear
    always_ff @(posedge clk) begin
        if (!rst_n_i)       r_last <= '0;
        else if (any_hit_o) r_last <= w_first;
    end

endmodule

// File: tb/tb_drum_hit_capture.sv
// tb_drum_hit_capture: directed and random checks of drum_hit_capture against a run-length reference model
module tb_drum_hit_capture;

    localparam int N = 3;
    localparam int D = 4;
    localparam int F = 2;
    localparam int W = 2;

    logic             clk = 1'b0;
    logic             rst_n_i, frame_tick_i, enable_i, clear_i;
    logic [N-1:0]     pad_raw_i, hit_pulse_o, hit_level_o, flash_o;
    logic [N*W-1:0]   hit_count_o, pre_counts;
    logic             any_hit_o;
    logic [1:0]       last_pad_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n;

    // Reference state: raw sample history, accepted level, run of disagreeing samples
    int h1[N], h2[N], lvl[N], run[N], pls[N], fl[N], cnt[N];
    int last;

    always #5 clk = ~clk;

    drum_hit_capture #(
        .N_PADS          (N),
        .DEBOUNCE_CYCLES (D),
        .FLASH_FRAMES    (F),
        .CNT_W           (W),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n_i      (rst_n_i),
        .pad_raw_i    (pad_raw_i),
        .frame_tick_i (frame_tick_i),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .hit_pulse_o  (hit_pulse_o),
        .hit_level_o  (hit_level_o),
        .flash_o      (flash_o),
        .hit_count_o  (hit_count_o),
        .any_hit_o    (any_hit_o),
        .last_pad_o   (last_pad_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge using the inputs present at that edge
    task automatic model_edge();
        int  fp;
        bit  any;
        if (!rst_n_i) begin
            for (int i = 0; i < N; i++) begin
                h1[i] = 0; h2[i] = 0; lvl[i] = 0; run[i] = 0; pls[i] = 0; fl[i] = 0; cnt[i] = 0;
            end
            last = 0;
            return;
        end
        any = 0;
        fp  = 0;
        for (int i = N - 1; i >= 0; i--) if (pls[i] != 0) begin any = 1; fp = i; end
        if (any) last = fp;
        for (int i = 0; i < N; i++) begin
            int s;
            if (pls[i] != 0) fl[i] = F;
            else if (frame_tick_i && fl[i] > 0) fl[i]--;
            if (clear_i) cnt[i] = 0;
            else if (enable_i && pls[i] != 0 && cnt[i] < (1 << W) - 1) cnt[i]++;
            s     = h2[i];
            h2[i] = h1[i];
            h1[i] = int'(pad_raw_i[i]);
            pls[i] = 0;
            if (s != lvl[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == D) begin
                lvl[i] = s;
                pls[i] = s;
                run[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]   ep, el, ef;
        logic [N*W-1:0] ec;
        for (int i = 0; i < N; i++) begin
            ep[i] = (pls[i] != 0);
            el[i] = (lvl[i] != 0);
            ef[i] = (fl[i] != 0);
            ec[i*W +: W] = W'(cnt[i]);
        end
        chk("pulse", hit_pulse_o, ep);
        chk("level", hit_level_o, el);
        chk("flash", flash_o, ef);
        chk("count", hit_count_o, ec);
        chk("any_hit", any_hit_o, |ep);
        chk("last_pad", last_pad_o, last);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input int p);
        pad_raw_i[p] = 1'b1;
        repeat (8) step();
        pad_raw_i[p] = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        rst_n_i = 1'b0; pad_raw_i = '0; frame_tick_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
        step();
        step();
        chk("rst_pulse", hit_pulse_o, 0);
        chk("rst_level", hit_level_o, 0);
        chk("rst_flash", flash_o, 0);
        chk("rst_count", hit_count_o, 0);
        chk("rst_last", last_pad_o, 0);
        rst_n_i = 1'b1;
        cyc = 0;

        // Clean press on pad1 held from edge 10
        while (cyc < 10) step();
        pad_raw_i[1] = 1'b1;
        while (cyc < 15) step();
        chk("clean_early", hit_pulse_o, 0);
        step();
        chk("clean_pulse", hit_pulse_o, 3'b010);
        chk("clean_level", hit_level_o[1], 1);
        step();
        chk("clean_single", hit_pulse_o, 0);
        chk("clean_last", last_pad_o, 1);
        chk("clean_count", hit_count_o[W +: W], 1);
        pad_raw_i[1] = 1'b0;
        repeat (8) step();
        chk("clean_release", hit_level_o[1], 0);

        // Bounce on pad0 never qualifies
        pad_raw_i[0] = 1'b1; repeat (3) step();
        pad_raw_i[0] = 1'b0; step();
        pad_raw_i[0] = 1'b1; repeat (2) step();
        pad_raw_i[0] = 1'b0; repeat (8) step();
        chk("bounce_level", hit_level_o[0], 0);
        chk("bounce_count", hit_count_o[0 +: W], 0);

        // Flash hold with a retrigger on a frame tick
        pad_raw_i[2] = 1'b1;
        for (int k = 0; k < 20 && !hit_pulse_o[2]; k++) step();
        chk("p2_pulse", hit_pulse_o[2], 1);
        step();
        chk("flash_on", flash_o[2], 1);
        frame_tick_i = 1'b1; step(); frame_tick_i = 1'b0;
        chk("flash_one_left", flash_o[2], 1);
        pad_raw_i[2] = 1'b0;
        for (int k = 0; k < 20 && hit_level_o[2]; k++) step();
        chk("p2_released", hit_level_o[2], 0);
        pad_raw_i[2] = 1'b1;
        for (int k = 0; k < 20 && !hit_pulse_o[2]; k++) step();
        chk("p2_repulse", hit_pulse_o[2], 1);
        frame_tick_i = 1'b1;
        step();
        chk("flash_retrig", flash_o[2], 1);
        step();
        chk("flash_reloaded", flash_o[2], 1);
        step();
        chk("flash_off", flash_o[2], 0);
        frame_tick_i = 1'b0;
        pad_raw_i[2] = 1'b0;
        repeat (8) step();

        // Saturation then clear beating a coincident hit
        repeat (5) press(0);
        chk("sat_count", hit_count_o[0 +: W], 3);
        pad_raw_i[0] = 1'b1;
        for (int k = 0; k < 20 && !hit_pulse_o[0]; k++) step();
        chk("p0_sixth", hit_pulse_o[0], 1);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        chk("clear_hit", hit_count_o[0 +: W], 0);
        pad_raw_i[0] = 1'b0;
        repeat (8) step();

        // Simultaneous hits with counting disabled
        enable_i   = 1'b0;
        pre_counts = hit_count_o;
        pad_raw_i  = 3'b101;
        for (int k = 0; k < 20 && !any_hit_o; k++) step();
        chk("simul_pulse", hit_pulse_o, 3'b101);
        chk("simul_any", any_hit_o, 1);
        step();
        chk("simul_last", last_pad_o, 0);
        chk("simul_counts", hit_count_o, pre_counts);
        chk("simul_flash", flash_o, 3'b101);
        pad_raw_i = '0;
        repeat (8) step();
        enable_i = 1'b1;

        // Reset mid-qualification restarts the full debounce
        pad_raw_i[1] = 1'b1;
        repeat (3) step();
        rst_n_i = 1'b0; step(); rst_n_i = 1'b1;
        chk("rst_pw_count", hit_count_o, 0);
        n = 0;
        while (!hit_pulse_o[1] && n < 20) begin step(); n++; end
        chk("rst_pw_latency", n, 6);
        pad_raw_i[1] = 1'b0;
        repeat (8) step();

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) pad_raw_i[i] = ~pad_raw_i[i];
            frame_tick_i = ($urandom_range(3) == 0);
            enable_i     = ($urandom_range(7) != 0);
            clear_i      = ($urandom_range(39) == 0);
            rst_n_i      = ($urandom_range(199) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_hit_capture.md
Name: drum_hit_capture

Overview:
Parametrised N-pad drum input front end that replaces the three hard-wired hat/cymbal/tom hit wires feeding the pattern generator. Per pad it provides a 2-FF synchroniser, a debounce FSM, a one-cycle hit pulse, a frame-timed flash hold for the display, and a saturating hit counter. It runs in the pixel-clock domain between the board pad pins and pattern_gen.

Parameters:
N_PADS, 3, number of drum pads (1..16)
DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles required to accept a press or release (>=2)
FLASH_FRAMES, 8, frame_tick_i pulses the flash output holds after a hit (>=1)
CNT_W, 8, width of each per-pad hit counter
ACTIVE_LOW, 0, 1 = raw pad inputs are active-low

Ports:
clk  in  1  pixel clock (PLL output)
rst_n_i  in  1  reset; synchronous, active-low
pad_raw_i  in  N_PADS  asynchronous raw pad inputs
frame_tick_i  in  1  one-cycle pulse per video frame, from the vsync start
enable_i  in  1  1 = counters accumulate hits
clear_i  in  1  synchronous clear of all hit counters
hit_pulse_o  out  N_PADS  one-cycle accepted-press pulse per pad
hit_level_o  out  N_PADS  debounced pressed level
flash_o  out  N_PADS  display flash hold
hit_count_o  out  N_PADS*CNT_W  saturating per-pad counts; pad i occupies bits [i*CNT_W +: CNT_W]
any_hit_o  out  1  OR of hit_pulse_o, same cycle
last_pad_o  out  $clog2(N_PADS) (min 1)  index of the most recent hit

Behaviour:
- Reset (rst_n_i=0 at a clk edge): synchronisers are loaded with the inactive level, FSMs go to IDLE, and all outputs are 0 (counts, flash, pulses, level, last_pad_o).
- s = synchroniser output after 2 stages, normalised to active-high via ACTIVE_LOW. cnt = debounce counter.
- Debounce FSM per pad, with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: s=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT: s=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and fire the pulse. Otherwise cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: s=1 -> PRESSED with no pulse. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
- hit_level_o=1 in PRESSED and RELEASE_WAIT.
- hit_pulse_o is registered. It is high for exactly one cycle, in the first cycle the FSM is in PRESSED. A raw input stable from edge k gives the pulse at edge k+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no pulse and no level change.
- Flash counter per pad, width $clog2(FLASH_FRAMES+1):
  - Hit pulse -> load FLASH_FRAMES (retrigger restarts the hold).
  - Else frame_tick_i with counter nonzero -> decrement.
  - Hit and tick in the same cycle: the load wins.
  - flash_o = (counter != 0).
- Hit counters:
  - clear_i -> 0. Clear beats a simultaneous hit, and that hit is lost.
  - Else enable_i && hit pulse -> +1, saturating at 2^CNT_W-1 with no wrap.
  - enable_i=0 does not affect pulses, level or flash.
- last_pad_o updates on any pulse, one cycle after it. Simultaneous pulses select the lowest index. It holds otherwise and is not affected by clear_i.
- Reset mid-debounce discards the press in progress. A pad still held after reset must complete a full DEBOUNCE_CYCLES qualification before it pulses.

Optional Feature:
HIT_TIMESTAMP_EN
- Defined:
  - Adds input seconds_i [5:0] (from the timer).
  - Adds output last_hit_sec_o [N_PADS*6], which latches seconds_i on each hit pulse of pad i, with 1 cycle latency.
  - last_hit_sec_o resets to 0 and is cleared by clear_i.
- Undefined: neither port exists and no timestamp logic is present.

Decomposition:
- Package drum_pkg holds:
  - the debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - localparam SYNC_STAGES=2;
  - the default DEBOUNCE_CYCLES for a 25.175 MHz pixel clock (≈10 ms);
  - a function for counter saturation max.
- Sub-module drum_debounce: one pad's synchroniser plus FSM plus pulse/level. It is instantiated N_PADS times in a generate loop.
- The top of the block holds flash, counters, the last_pad encoder and the timestamps.

Test Plan:
All scenarios use N_PADS=3, DEBOUNCE_CYCLES=4, FLASH_FRAMES=2, CNT_W=2.
- Clean press: pad1 raw 0->1 held from edge 10 -> hit_pulse_o=3'b010 only at edge 16; hit_level_o[1]=1; last_pad_o=1 at edge 17; count1=1.
- Bounce: pad0 high 3 cycles, low 1, high 2, then low -> no pulse, hit_level_o[0] stays 0, count0=0.
- Flash: hit on pad2, then 2 frame_tick_i pulses -> flash_o[2] falls after the 2nd tick. Retrigger with a hit coincident with the 2nd tick -> flash_o[2] stays 1 and the counter is reloaded to 2.
- Saturation/clear: 5 qualified presses on pad0 -> count0=3. clear_i coincident with a 6th pulse -> count0=0.
- Simultaneous: pads 0 and 2 pressed on the same edge -> hit_pulse_o=3'b101, any_hit_o=1, last_pad_o=0. With enable_i=0, counts unchanged.
- Reset mid-PRESS_WAIT while pad held -> no pulse until 4+2 cycles after rst_n_i returns high.
